prbs_lfsr_checker: RTL and testbench
====================================

// Module: prbs_lfsr_checker
// PURPOSE
//  Receive-side checker for the LFSR pseudo-random stream produced by our PRNG generator.
//  - Self-synchronises to an incoming WIDTH-bit word stream.
//  - Predicts each next word and compares it with the received word.
//  - Reports lock status and per-word errors, and keeps a saturating error count.
//  - Sits at the far end of a link/BIST path, opposite the generator.
// PARAMETERS
//  WIDTH      4        LFSR/word width (>=3)
//  TAPS       4'b1100  feedback mask; default = x^4+x^3+1, period 15
//  LOCK_CNT   4        consecutive correct predictions needed to declare lock
//  UNLOCK_CNT 3        consecutive mispredictions (while locked) that drop lock
//  ERR_W      16       error counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_data is valid this cycle
//  in_data    in   WIDTH  received generator word
//  clr_count  in   1      synchronous clear of err_count
//  locked     out  1      checker locked to the stream
//  err_pulse  out  1      one-cycle flag: last valid word mispredicted while locked
//  err_count  out  ERR_W  saturating count of locked-state mismatches
// BEHAVIOUR
//  - Next-state function: nxt(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
//  - Reset (rst=1 at a posedge): state=HUNT; pred=0; seeded=0; match_run=0; miss_run=0;
//    locked=0; err_pulse=0; err_count=0. Reset mid-lock discards all history.
//  - All outputs are registered. Each reacts 1 cycle after the in_valid word that caused it.
//  - in_valid=0: all state holds. err_pulse=0.
//  - HUNT (locked=0):
//     - in_data==0 (lockup word): seeded=0, match_run=0.
//     - else if seeded && in_data==pred: match_run++.
//       match_run reaching LOCK_CNT -> go to LOCKED, miss_run=0.
//     - else: seeded=1, match_run=0.
//     - In every nonzero case above: pred <= nxt(in_data).
//     - No errors are counted in HUNT. err_pulse stays 0.
//  - LOCKED (locked=1): flywheel mode. pred <= nxt(pred) on every valid word; no re-seeding.
//     - Mismatch: err_pulse=1; err_count++ (saturates at all-ones); miss_run++.
//       miss_run reaching UNLOCK_CNT -> go to HUNT, seeded=0, match_run=0.
//     - Match: miss_run=0.
//  - clr_count: err_count <= 0. If a mismatch occurs in the same cycle, err_count <= 1.
//  - rst has priority over everything.
//  - Counters match_run and miss_run are sized clog2 of their limit + 1. They never wrap.
// STRUCTURE
//  - Shared package prbs_pkg: state enum {HUNT, LOCKED}; default TAPS constants per WIDTH;
//    function lfsr_next(s, taps), the same function the generator uses.
//  - Single module. No sub-module needed: FSM, predictor register and counters are all local.
// TESTING (WIDTH=4, TAPS=1100, LOCK_CNT=4, UNLOCK_CNT=3)
//  1. After reset, feed valid 0001,0010,0100,1001,0011
//     -> locked=1 the cycle after 0011; err_count=0.
//  2. Locked at 0011, feed 0000 (expected 0110), then 1101
//     -> err_pulse=1 for one cycle; err_count=1; locked stays 1; 1101 matches.
//  3. Locked, feed 1111,1111,1111 (all wrong)
//     -> err_count +3; locked=0 the cycle after the third; HUNT relocks after 5 good words.
//  4. ERR_W=2, locked, inject 5 mismatches spaced by 2 good words -> err_count sticks at 3.
//     Then clr_count together with a mismatch -> err_count=1.
//  5. Feed the lock sequence with in_valid gaps (1,0,0,1,...)
//     -> same lock timing counted in valid words; no err_pulse during gaps.
//  6. Assert rst while locked with err_count=2
//     -> next cycle locked=0, err_count=0, err_pulse=0; relock requires 5 fresh words.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default feedback masks and the
// LFSR next-state function used by both generator and checker.
package prbs_pkg;

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int unsigned MAX_W = 32;

  // Maximal-length Fibonacci masks, bit WIDTH-1 is the x^WIDTH tap.
  function automatic logic [MAX_W-1:0] default_taps(input int unsigned width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0003 << (width - 2);
    endcase
  endfunction

  // nxt(s) = {s[width-2:0], ^(s & taps)}, computed in a MAX_W container.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] taps,
                                                 input int unsigned      width);
    logic [MAX_W-1:0] mask;
    mask = '1 >> (MAX_W - width);
    return ((s << 1) | MAX_W'(^(s & taps & mask))) & mask;
  endfunction

endpackage

// File: rtl/prbs_lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to the incoming LFSR word stream,
// flywheels once locked, and flags/counts mispredicted words.
module prbs_lfsr_checker
  import prbs_pkg::*;
#(
  parameter int unsigned             WIDTH      = 4,
  parameter logic [WIDTH-1:0]        TAPS       = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned             LOCK_CNT   = 4,
  parameter int unsigned             UNLOCK_CNT = 3,
  parameter int unsigned             ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned MR_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(UNLOCK_CNT + 1);

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] s);
    return WIDTH'(lfsr_next(MAX_W'(s), MAX_W'(TAPS), WIDTH));
  endfunction

  state_t           state, state_n;
  logic [WIDTH-1:0] pred, pred_n;
  logic             seeded, seeded_n;
  logic [MR_W-1:0]  match_run, match_run_n;
  logic [MS_W-1:0]  miss_run, miss_run_n;
  logic             err_pulse_n;
  logic [ERR_W-1:0] err_count_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= '0;
      seeded    <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      pred      <= pred_n;
      seeded    <= seeded_n;
      match_run <= match_run_n;
      miss_run  <= miss_run_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    pred_n      = pred;
    seeded_n    = seeded;
    match_run_n = match_run;
    miss_run_n  = miss_run;
    err_pulse_n = 1'b0;
    err_count_n = clr_count ? '0 : err_count;

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data == '0) begin
            // All-zero is the LFSR lockup word: it can never seed a valid prediction.
            seeded_n    = 1'b0;
            match_run_n = '0;
          end else begin
            pred_n = nxt(in_data);
            if (seeded && (in_data == pred)) begin
              match_run_n = match_run + 1'b1;
              if (match_run == MR_W'(LOCK_CNT - 1)) begin
                state_n    = LOCKED;
                miss_run_n = '0;
              end
            end else begin
              seeded_n    = 1'b1;
              match_run_n = '0;
            end
          end
        end

        LOCKED: begin
          pred_n = nxt(pred);
          if (in_data != pred) begin
            err_pulse_n = 1'b1;
            if (clr_count)
              err_count_n = ERR_W'(1);
            else if (err_count != '1)
              err_count_n = err_count + 1'b1;
            miss_run_n = miss_run + 1'b1;
            if (miss_run == MS_W'(UNLOCK_CNT - 1)) begin
              state_n     = HUNT;
              seeded_n    = 1'b0;
              match_run_n = '0;
            end
          end else begin
            miss_run_n = '0;
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// Bench for prbs_lfsr_checker: directed vector table, hand sequences for counter
// saturation/clear, and randomized stream checked against an arithmetic model.
module tb_prbs_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_count;
  logic [3:0]  in_data;
  logic        locked0, pulse0, locked1, pulse1;
  logic [15:0] count0;
  logic [1:0]  count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prbs_lfsr_checker #(.WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_count(clr_count),
    .locked(locked0), .err_pulse(pulse0), .err_count(count0));

  prbs_lfsr_checker #(.WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_count(clr_count),
    .locked(locked1), .err_pulse(pulse1), .err_count(count1));

  // Reference model, one slot per DUT (slot 1 has a 2-bit counter).
  int m_locked[2], m_seeded[2], m_pred[2], m_match[2], m_miss[2], m_pulse[2], m_cnt[2];
  int m_max[2] = '{65535, 3};

  function automatic int nxt(int s);
    int fb;
    fb = $countones(s & 12) % 2;
    return (s * 2 + fb) % 16;
  endfunction

  function automatic void model_step(bit r, bit v, int d, bit c);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_locked[i] = 0; m_seeded[i] = 0; m_pred[i] = 0; m_match[i] = 0;
        m_miss[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0;
        continue;
      end
      m_pulse[i] = 0;
      if (c) m_cnt[i] = 0;
      if (!v) continue;
      if (m_locked[i] == 0) begin
        if (d == 0) begin
          m_seeded[i] = 0; m_match[i] = 0;
        end else begin
          if (m_seeded[i] != 0 && d == m_pred[i]) begin
            m_match[i]++;
            if (m_match[i] == 4) begin m_locked[i] = 1; m_miss[i] = 0; end
          end else begin
            m_seeded[i] = 1; m_match[i] = 0;
          end
          m_pred[i] = nxt(d);
        end
      end else begin
        bit mis;
        mis = (d != m_pred[i]);
        m_pred[i] = nxt(m_pred[i]);
        if (mis) begin
          m_pulse[i] = 1;
          m_cnt[i] = c ? 1 : ((m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1);
          m_miss[i]++;
          if (m_miss[i] == 3) begin m_locked[i] = 0; m_seeded[i] = 0; m_match[i] = 0; end
        end else begin
          m_miss[i] = 0;
        end
      end
    end
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(bit r, bit v, int d, bit c);
    rst = r; in_valid = v; in_data = 4'(d); clr_count = c;
    @(posedge clk);
    model_step(r, v, d, c);
    #1;
    check("m_lock0",  int'(locked0), m_locked[0]);
    check("m_pulse0", int'(pulse0),  m_pulse[0]);
    check("m_cnt0",   int'(count0),  m_cnt[0]);
    check("m_lock1",  int'(locked1), m_locked[1]);
    check("m_pulse1", int'(pulse1),  m_pulse[1]);
    check("m_cnt1",   int'(count1),  m_cnt[1]);
  endtask

  typedef struct {
    bit r; bit v; int d; bit c;
    bit lk; bit ep; int cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int d, bit c, bit lk, bit ep, int cnt);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.c = c; e.lk = lk; e.ep = ep; e.cnt = cnt;
    return e;
  endfunction

  vec_t tbl[$];

  initial begin
    int w, gen, d, pick;
    bit r, v, c;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_count = 1'b0;

    // reset, then lock on 0001,0010,0100,1001,0011
    tbl.push_back(mk(1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0));
    tbl.push_back(mk(0,1,2,0, 0,0,0));
    tbl.push_back(mk(0,1,4,0, 0,0,0));
    tbl.push_back(mk(0,1,9,0, 0,0,0));
    tbl.push_back(mk(0,1,3,0, 1,0,0));
    // locked: 0000 mispredicts (0110 expected), 1101 matches
    tbl.push_back(mk(0,1,0,0, 1,1,1));
    tbl.push_back(mk(0,1,13,0, 1,0,1));
    // three wrong words drop lock
    tbl.push_back(mk(0,1,15,0, 1,1,2));
    tbl.push_back(mk(0,1,15,0, 1,1,3));
    tbl.push_back(mk(0,1,15,0, 0,1,4));
    // relock after five good words
    tbl.push_back(mk(0,1,1,0, 0,0,4));
    tbl.push_back(mk(0,1,2,0, 0,0,4));
    tbl.push_back(mk(0,1,4,0, 0,0,4));
    tbl.push_back(mk(0,1,9,0, 0,0,4));
    tbl.push_back(mk(0,1,3,0, 1,0,4));
    // lock sequence with in_valid gaps
    tbl.push_back(mk(1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0));
    tbl.push_back(mk(0,0,7,0, 0,0,0));
    tbl.push_back(mk(0,0,7,0, 0,0,0));
    tbl.push_back(mk(0,1,2,0, 0,0,0));
    tbl.push_back(mk(0,0,7,0, 0,0,0));
    tbl.push_back(mk(0,1,4,0, 0,0,0));
    tbl.push_back(mk(0,1,9,0, 0,0,0));
    tbl.push_back(mk(0,0,7,0, 0,0,0));
    tbl.push_back(mk(0,1,3,0, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0));
    // two errors, a match, then reset while locked
    tbl.push_back(mk(0,1,0,0, 1,1,1));
    tbl.push_back(mk(0,1,0,0, 1,1,2));
    tbl.push_back(mk(0,1,10,0, 1,0,2));
    tbl.push_back(mk(1,1,10,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0));
    tbl.push_back(mk(0,1,2,0, 0,0,0));
    tbl.push_back(mk(0,1,4,0, 0,0,0));
    tbl.push_back(mk(0,1,9,0, 0,0,0));
    tbl.push_back(mk(0,1,3,0, 1,0,0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d_lock", i),  int'(locked0), int'(tbl[i].lk));
      check($sformatf("tbl%0d_pulse", i), int'(pulse0),  int'(tbl[i].ep));
      check($sformatf("tbl%0d_cnt", i),   int'(count0),  tbl[i].cnt);
    end

    // Saturation: 5 mismatches separated by 2 good words; 2-bit counter sticks at 3.
    w = 3;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, nxt(w) ^ 1, 0);
      w = nxt(w);
      check("sat_cnt0", int'(count0), k + 1);
      check("sat_cnt1", int'(count1), (k < 3) ? k + 1 : 3);
      check("sat_lock", int'(locked1), 1);
      repeat (2) begin
        w = nxt(w);
        step(0, 1, w, 0);
      end
    end
    step(0, 1, nxt(w) ^ 1, 1);
    w = nxt(w);
    check("clr_mis_cnt1", int'(count1), 1);
    check("clr_mis_cnt0", int'(count0), 1);
    check("clr_mis_pulse", int'(pulse1), 1);
    w = nxt(w);
    step(0, 1, w, 1);
    check("clr_match_cnt0", int'(count0), 0);

    // Randomized stream against the model.
    w = 1;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      gen = nxt(w);
      pick = $urandom_range(0, 19);
      if (pick < 17)      d = gen;
      else if (pick == 17) d = 0;
      else                d = $urandom_range(0, 15);
      if (v) w = gen;
      step(r, v, d, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
